motor_ramp_sequencer: RTL and testbench
=======================================

Name: motor_ramp_sequencer

Overview:
- Sequencer that sits between NIOS-driven command registers and the PWM/H-bridge motor driver stage.
- Accepts (duty %, direction) commands over a valid/ready handshake.
- Ramps the duty setpoint toward the target at a fixed rate instead of stepping it.
- On direction reversal: ramps to zero, dwells with the bridge off, swaps the direction pins, then ramps back up. Provides an emergency-stop override.

Parameters:
- STEP_DIV, 120000, clocks per ramp tick (10 ms at 12 MHz); legal range >= 2.
- DUTY_STEP, 1, duty % change per tick; legal range 1..100.
- DWELL_TICKS, 25, ramp ticks spent with the bridge off during reversal; legal range >= 1.
- MAX_DUTY, 100, clamp ceiling for commanded duty; legal range <= 100.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous, active-low reset.
- cmd_valid, in, 1: command present.
- cmd_ready, out, 1: command accepted when cmd_valid and cmd_ready are both high on a clk edge.
- cmd_duty, in, 7: target duty in %.
- cmd_dir, in, 1: target direction; 0 = forward, 1 = reverse.
- estop, in, 1: synchronous level-sensitive emergency stop.
- duty, out, 7: current duty setpoint fed to the PWM comparator.
- dir_pin_1, out, 1: H-bridge input 1.
- dir_pin_2, out, 1: H-bridge input 2.
- busy, out, 1: high whenever state is not IDLE.
- state, out, 2: IDLE=0, RAMP=1, STOP=2, DWELL=3.

Behaviour:
- Reset (async, rst_n=0):
  - duty=0, cur_dir=0, dir_pin_1=0, dir_pin_2=1, state=IDLE, busy=0, cmd_ready=1.
  - Tick counter=0; dwell counter=0; target=0.
- Direction pin encoding when driving:
  - cur_dir=0: dir_pin_1=0, dir_pin_2=1.
  - cur_dir=1: dir_pin_1=1, dir_pin_2=0.
  - "Off": both pins 0 (coast).
- Tick generation:
  - Free-running counter 0..STEP_DIV-1; tick=1 in the cycle where counter==STEP_DIV-1, then the counter wraps to 0.
  - Cleared only by reset; not resynchronised by commands.
- Handshake:
  - cmd_ready = (state==IDLE) && !estop.
  - Accepted cmd_duty is clamped to MAX_DUTY; values 101..127 also clamp.
  - New state is visible on the cycle after accept.
- IDLE accept decision:
  - Same direction (cmd_dir==cur_dir): target=clamp. If target==duty, remain IDLE (busy stays 0); else go to RAMP.
  - Direction differs and duty==0: cur_dir and pins update on the next edge. Then RAMP if target!=0, else IDLE. No dwell in this case.
  - Direction differs and duty>0: latch pend_dir and pend_target, go to STOP.
- RAMP:
  - On each tick, duty moves toward target by min(DUTY_STEP, |target-duty|). Never overshoots.
  - When duty==target, go to IDLE on the following edge.
- STOP:
  - On each tick, duty decreases by min(DUTY_STEP, duty).
  - When duty reaches 0, go to DWELL: pins go off and the dwell counter is cleared.
- DWELL:
  - The dwell counter increments per tick.
  - After DWELL_TICKS ticks: cur_dir=pend_dir, pins driven for the new direction, target=pend_target, go to RAMP.
  - If pend_target==0, go to IDLE instead.
- estop (priority over everything except reset):
  - While high: duty=0 on the next edge, pins off, target=0, state=IDLE, cmd_ready=0.
  - Any pending reversal is discarded; cur_dir is retained.
  - On release: pins return to cur_dir encoding on the next edge, duty stays 0, cmd_ready=1.
  - estop coincident with cmd_valid: the command is not accepted.
- Reset asserted mid-sequence returns all outputs to their reset values immediately, regardless of state.
- duty never exceeds MAX_DUTY; all arithmetic is 7-bit unsigned with explicit min() clipping, so no wrap-around.

Optional Feature:
- Macro MOTOR_BRAKE_EN.
- Defined: every "pins off" condition (DWELL, estop) drives dir_pin_1=1 and dir_pin_2=1 (active brake).
- Undefined: "pins off" drives both pins to 0 (coast).
- All other behaviour is identical in both builds.

Test Plan:
- Test parameters unless stated: STEP_DIV=4, DUTY_STEP=10, DWELL_TICKS=2, MAX_DUTY=100.
- Reset mid-ramp: assert rst_n=0 -> duty=0, pins 0/1, state=0, cmd_ready=1 without waiting for a clk edge.
- Command 50, dir 0 from reset: accepted in 1 cycle -> duty 10,20,30,40,50 on successive ticks (4 clks apart) -> busy falls 1 clk after duty reaches 50, state=0.
- Reversal from 50 fwd, command 30 dir 1: duty 40..0 over 5 ticks, state=2 -> pins 0/0, state=3 for 2 ticks -> pins 1/0, duty 10,20,30, then IDLE.
- Clamp and non-multiple target: command 120 -> final duty 100. From 0, command 35 -> 10,20,30,35 with no overshoot.
- estop pulsed high at duty=30 during a ramp to 60 with cmd_valid held: duty=0 and pins 0/0 next clk, cmd_ready=0, no accept -> release -> pins 0/1, IDLE, cmd_ready=1.
- Build with MOTOR_BRAKE_EN and repeat the reversal test -> pins read 1/1 throughout DWELL and during estop.

Source files
------------

// File: rtl/motor_ramp_sequencer_if.sv
// motor_ramp_sequencer_if: duty/direction command handshake into the motor ramp sequencer.
interface motor_ramp_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_duty;
    logic       cmd_dir;
    modport master (output cmd_valid, output cmd_duty, output cmd_dir, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_duty, input cmd_dir, output cmd_ready);
endinterface

// File: rtl/motor_ramp_sequencer.sv
// motor_ramp_sequencer: ramps the PWM duty setpoint toward commanded targets, with dwell-protected reversal and estop.
// Define MOTOR_BRAKE_EN to brake (both bridge inputs high) instead of coasting whenever the bridge is off.
module motor_ramp_sequencer #(
    parameter int STEP_DIV    = 120000,
    parameter int DUTY_STEP   = 1,
    parameter int DWELL_TICKS = 25,
    parameter int MAX_DUTY    = 100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    motor_ramp_sequencer_if.slave  cmd,
    input  logic                   estop,
    output logic [6:0]             duty,
    output logic                   dir_pin_1,
    output logic                   dir_pin_2,
    output logic                   busy,
    output logic [1:0]             state
);
    localparam int CW = $clog2(STEP_DIV);
    localparam int DW = $clog2(DWELL_TICKS + 1);
`ifdef MOTOR_BRAKE_EN
    localparam logic [1:0] OFF_PINS = 2'b11;
`else
    localparam logic [1:0] OFF_PINS = 2'b00;
`endif
    typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, STOP = 2'd2, DWELL = 2'd3} state_t;
    state_t        st, st_n;
    logic [CW-1:0] tick_cnt;
    logic [DW-1:0] dwell_cnt, dwell_cnt_n;
    logic [6:0]    duty_n, target, target_n, pend_target, pend_target_n;
    logic [6:0]    clamped, diff, step, down;
    logic          cur_dir, cur_dir_n, pend_dir, pend_dir_n, off, off_n, tick, accept;

    assign tick           = tick_cnt == CW'(STEP_DIV - 1);
    assign cmd.cmd_ready  = st == IDLE && !estop;
    assign accept         = cmd.cmd_valid && cmd.cmd_ready;
    assign clamped        = cmd.cmd_duty > 7'(MAX_DUTY) ? 7'(MAX_DUTY) : cmd.cmd_duty;
    assign diff           = target > duty ? target - duty : duty - target;
    assign step           = diff < 7'(DUTY_STEP) ? diff : 7'(DUTY_STEP);
    assign down           = duty < 7'(DUTY_STEP) ? duty : 7'(DUTY_STEP);
    assign busy           = st != IDLE;
    assign state          = st;
    assign {dir_pin_1, dir_pin_2} = off ? OFF_PINS : {cur_dir, !cur_dir};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            tick_cnt <= '0;
        else
            tick_cnt <= tick ? '0 : tick_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st          <= IDLE;
            duty        <= '0;
            target      <= '0;
            cur_dir     <= 1'b0;
            pend_dir    <= 1'b0;
            pend_target <= '0;
            dwell_cnt   <= '0;
            off         <= 1'b0;
        end else begin
            st          <= st_n;
            duty        <= duty_n;
            target      <= target_n;
            cur_dir     <= cur_dir_n;
            pend_dir    <= pend_dir_n;
            pend_target <= pend_target_n;
            dwell_cnt   <= dwell_cnt_n;
            off         <= off_n;
        end

    // estop overrides every state; the bridge stays off for as long as it is held
    always_comb begin
        st_n          = st;
        duty_n        = duty;
        target_n      = target;
        cur_dir_n     = cur_dir;
        pend_dir_n    = pend_dir;
        pend_target_n = pend_target;
        dwell_cnt_n   = dwell_cnt;
        off_n         = 1'b0;
        if (estop) begin
            st_n     = IDLE;
            duty_n   = '0;
            target_n = '0;
            off_n    = 1'b1;
        end else begin
            case (st)
                IDLE: if (accept) begin
                    if (cmd.cmd_dir == cur_dir) begin
                        target_n = clamped;
                        st_n     = clamped == duty ? IDLE : RAMP;
                    end else if (duty == '0) begin
                        cur_dir_n = cmd.cmd_dir;
                        target_n  = clamped;
                        st_n      = clamped != '0 ? RAMP : IDLE;
                    end else begin
                        pend_dir_n    = cmd.cmd_dir;
                        pend_target_n = clamped;
                        st_n          = STOP;
                    end
                end
                RAMP: if (duty == target) st_n = IDLE;
                      else if (tick) duty_n = target > duty ? duty + step : duty - step;
                STOP: if (duty == '0) begin
                    st_n        = DWELL;
                    dwell_cnt_n = '0;
                    off_n       = 1'b1;
                end else if (tick) duty_n = duty - down;
                DWELL: begin
                    off_n = 1'b1;
                    if (tick && dwell_cnt == DW'(DWELL_TICKS - 1)) begin
                        cur_dir_n = pend_dir;
                        target_n  = pend_target;
                        off_n     = 1'b0;
                        st_n      = pend_target != '0 ? RAMP : IDLE;
                    end else if (tick) dwell_cnt_n = dwell_cnt + DW'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// tb_motor_ramp_sequencer: directed, table-driven and randomized checks of the motor ramp sequencer.
module tb_motor_ramp_sequencer;
    localparam int STEP_DIV = 4, DUTY_STEP = 10, DWELL_TICKS = 2, MAX_DUTY = 100;
`ifdef MOTOR_BRAKE_EN
    localparam logic [1:0] OFFP = 2'b11;
`else
    localparam logic [1:0] OFFP = 2'b00;
`endif
    localparam logic [1:0] FWD = 2'b01, REV = 2'b10;

    typedef int iq_t[$];
    typedef struct { int d; bit dir; int exp_duty; logic [1:0] exp_pins; } vec_t;

    logic clk = 1'b0, rst_n = 1'b1, estop = 1'b0, busy, p1, p2;
    logic [6:0] duty;
    logic [1:0] state;
    int n_cmp = 0, n_bad = 0;

    motor_ramp_sequencer_if cmd();
    motor_ramp_sequencer #(.STEP_DIV(STEP_DIV), .DUTY_STEP(DUTY_STEP), .DWELL_TICKS(DWELL_TICKS), .MAX_DUTY(MAX_DUTY)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .estop(estop), .duty(duty),
        .dir_pin_1(p1), .dir_pin_2(p2), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: spec rules in plain arithmetic, tick derived from edges since reset
    int m_duty, m_dir, m_state, m_tgt, m_pdir, m_ptgt, m_ticks, m_edge;
    bit m_es;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_duty = 0; m_dir = 0; m_state = 0; m_tgt = 0; m_pdir = 0; m_ptgt = 0; m_ticks = 0; m_edge = 0; m_es = 0;
        end else begin
            bit tk;
            int c;
            tk = (m_edge % STEP_DIV) == STEP_DIV - 1;
            m_edge++;
            m_es = estop;
            c = cmd.cmd_duty > MAX_DUTY ? MAX_DUTY : int'(cmd.cmd_duty);
            if (estop) begin
                m_duty = 0; m_tgt = 0; m_state = 0;
            end else if (m_state == 0) begin
                if (cmd.cmd_valid && cmd.cmd_dir == m_dir[0]) begin
                    m_tgt = c; m_state = (c != m_duty) ? 1 : 0;
                end else if (cmd.cmd_valid && m_duty == 0) begin
                    m_dir = cmd.cmd_dir; m_tgt = c; m_state = (c != 0) ? 1 : 0;
                end else if (cmd.cmd_valid) begin
                    m_pdir = cmd.cmd_dir; m_ptgt = c; m_state = 2;
                end
            end else if (m_state == 1) begin
                if (m_duty == m_tgt) m_state = 0;
                else if (tk) m_duty = (m_tgt > m_duty) ? ((m_duty + DUTY_STEP < m_tgt) ? m_duty + DUTY_STEP : m_tgt)
                                                     : ((m_duty - DUTY_STEP > m_tgt) ? m_duty - DUTY_STEP : m_tgt);
            end else if (m_state == 2) begin
                if (m_duty == 0) begin m_state = 3; m_ticks = 0; end
                else if (tk) m_duty = (m_duty > DUTY_STEP) ? m_duty - DUTY_STEP : 0;
            end else if (tk) begin
                m_ticks++;
                if (m_ticks == DWELL_TICKS) begin
                    m_dir = m_pdir; m_tgt = m_ptgt; m_state = (m_ptgt != 0) ? 1 : 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] ep;
        ep = (m_state == 3 || m_es) ? OFFP : (m_dir != 0 ? REV : FWD);
        check("model_duty", duty, m_duty);
        check("model_pins", {p1, p2}, ep);
        check("model_state", state, m_state);
        check("model_busy", busy, m_state != 0);
        check("model_ready", cmd.cmd_ready, m_state == 0 && !estop);
    end

    logic [6:0] tr_d[$];
    logic [1:0] tr_s[$], tr_p[$];
    iq_t ch, gap, e;
    int last_ch;

    task automatic send(input int d, input bit dr);
        cmd.cmd_duty = 7'(d); cmd.cmd_dir = dr; cmd.cmd_valid = 1'b1;
        check("send_ready", cmd.cmd_ready, 1);
        @(posedge clk); #1 cmd.cmd_valid = 1'b0;
    endtask

    task automatic trace(input int budget);
        int n = 0;
        tr_d.delete(); tr_s.delete(); tr_p.delete();
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
            tr_d.push_back(duty); tr_s.push_back(state); tr_p.push_back({p1, p2});
        end
        check("idle_within_budget", busy, 0);
    endtask

    task automatic analyze(input int start);
        int prev = start;
        last_ch = -1; ch.delete(); gap.delete();
        foreach (tr_d[i]) if (int'(tr_d[i]) != prev) begin
            ch.push_back(int'(tr_d[i]));
            if (last_ch >= 0) gap.push_back(i - last_ch);
            last_ch = i; prev = int'(tr_d[i]);
        end
    endtask

    task automatic cmp_seq(input string name, input iq_t got, input iq_t exp);
        check({name, "_len"}, got.size(), exp.size());
        foreach (exp[i]) if (i < got.size()) check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
    endtask

    task automatic wait_duty(input int v);
        int n = 0;
        while (duty != 7'(v) && n < 100) begin @(posedge clk); #1; n++; end
        check("reach_duty", duty, v);
    endtask

    initial begin
        vec_t tbl[9];
        int n2, n3, bad;
        tbl = '{'{120, 1, 100, REV}, '{100, 1, 100, REV}, '{0, 1, 0, REV}, '{35, 0, 35, FWD}, '{127, 0, 100, FWD},
                '{7, 1, 7, REV}, '{0, 0, 0, FWD}, '{0, 1, 0, REV}, '{0, 0, 0, FWD}};
        cmd.cmd_valid = 1'b0; cmd.cmd_duty = '0; cmd.cmd_dir = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_duty", duty, 0); check("rst_pins", {p1, p2}, FWD); check("rst_state", state, 0);
        check("rst_busy", busy, 0); check("rst_ready", cmd.cmd_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        send(50, 0);
        check("ramp50_accept_state", state, 1);
        trace(100);
        analyze(0);
        e = '{10, 20, 30, 40, 50}; cmp_seq("ramp50_vals", ch, e);
        e = '{4, 4, 4, 4};         cmp_seq("ramp50_gaps", gap, e);
        check("ramp50_busy_fall", tr_d.size() - 1 - last_ch, 1);
        check("ramp50_final_state", state, 0);

        send(30, 1);
        check("rev_accept_state", state, 2);
        trace(200);
        analyze(50);
        e = '{40, 30, 20, 10, 0, 10, 20, 30}; cmp_seq("rev_vals", ch, e);
        n2 = 0; n3 = 0; bad = 0;
        foreach (tr_s[i]) begin
            if (tr_s[i] == 2) n2++;
            if (tr_s[i] == 3) n3++;
            if (tr_p[i] != (tr_s[i] == 2 ? FWD : tr_s[i] == 3 ? OFFP : REV)) bad++;
            if (tr_s[i] == 3 && tr_d[i] != 0) bad++;
        end
        check("rev_stop_seen", n2 > 0, 1);
        check("rev_dwell_len", n3 >= STEP_DIV + 1 && n3 <= 2 * STEP_DIV, 1);
        check("rev_pins_per_state", bad, 0);

        foreach (tbl[i]) begin
            send(tbl[i].d, tbl[i].dir);
            trace(300);
            check($sformatf("tbl%0d_duty", i), duty, tbl[i].exp_duty);
            check($sformatf("tbl%0d_pins", i), {p1, p2}, tbl[i].exp_pins);
            check($sformatf("tbl%0d_state", i), state, 0);
        end

        send(35, 0);
        trace(100);
        analyze(0);
        e = '{10, 20, 30, 35}; cmp_seq("noovershoot_vals", ch, e);

        send(0, 0);
        trace(100);
        send(60, 0);
        wait_duty(30);
        estop = 1'b1; cmd.cmd_valid = 1'b1; cmd.cmd_duty = 7'd80; cmd.cmd_dir = 1'b1;
        #1 check("es_ready_low", cmd.cmd_ready, 0);
        @(posedge clk); #1;
        check("es_duty", duty, 0); check("es_pins", {p1, p2}, OFFP); check("es_state", state, 0);
        check("es_busy", busy, 0); check("es_ready", cmd.cmd_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check("es_hold_duty", duty, 0); check("es_hold_state", state, 0); check("es_hold_pins", {p1, p2}, OFFP);
        estop = 1'b0; cmd.cmd_valid = 1'b0;
        #1 check("es_rel_ready", cmd.cmd_ready, 1);
        @(posedge clk); #1;
        check("es_rel_pins", {p1, p2}, FWD); check("es_rel_state", state, 0); check("es_rel_duty", duty, 0);

        send(50, 0);
        wait_duty(20);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_duty", duty, 0); check("midrst_pins", {p1, p2}, FWD); check("midrst_state", state, 0);
        check("midrst_busy", busy, 0); check("midrst_ready", cmd.cmd_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 800; i++) begin
            cmd.cmd_valid = $urandom_range(0, 3) == 0;
            cmd.cmd_duty  = 7'($urandom_range(0, 127));
            cmd.cmd_dir   = 1'($urandom_range(0, 1));
            estop         = $urandom_range(0, 59) == 0;
            @(posedge clk); #1;
        end
        cmd.cmd_valid = 1'b0; estop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
